// File: rtl/rx_ccsk_pkg.sv
// Shared types and helpers for the CCSK correlation engine.
package rx_ccsk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_HOLD
  } state_e;

  localparam int unsigned CCSK_SEQ_NUM = 2 ** 5;
  localparam int unsigned POP_MAX_W    = 256;

  function automatic int unsigned calc_pw(input int unsigned chip_w);
    return $clog2(chip_w + 1);
  endfunction

  function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < POP_MAX_W; i++) begin
      n += 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/rx_ccsk_lane_max.sv
// Per-row correlation stages: registered lane agreement counts, then a
// registered lane max / second-max with the winning lane index.
module rx_ccsk_lane_max
  import rx_ccsk_pkg::*;
#(
  parameter int unsigned CHIP_W = 32,
  parameter int unsigned LANES  = 4,
  parameter int unsigned PW     = 6,
  parameter int unsigned LIDX_W = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [CHIP_W-1:0]       word_i,
  input  logic [LANES*CHIP_W-1:0] seq_i,
  output logic [PW-1:0]           max_o,
  output logic [PW-1:0]           sec_o,
  output logic [LIDX_W-1:0]       idx_o
);

  logic [PW-1:0]     agree_d [LANES];
  logic [PW-1:0]     agree_q [LANES];
  logic [PW-1:0]     max_d, max_q;
  logic [PW-1:0]     sec_d, sec_q;
  logic [LIDX_W-1:0] idx_d, idx_q;

  always_comb begin
    for (int unsigned j = 0; j < LANES; j++) begin
      agree_d[j] = PW'(CHIP_W - popcount(POP_MAX_W'(word_i ^ seq_i[j*CHIP_W +: CHIP_W])));
    end
  end

  // Strict compares keep the lower lane index on ties.
  always_comb begin
    max_d = agree_q[0];
    sec_d = '0;
    idx_d = '0;
    for (int unsigned j = 1; j < LANES; j++) begin
      if (agree_q[j] > max_d) begin
        sec_d = max_d;
        max_d = agree_q[j];
        idx_d = LIDX_W'(j);
      end else if (agree_q[j] > sec_d) begin
        sec_d = agree_q[j];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned j = 0; j < LANES; j++) begin
        agree_q[j] <= '0;
      end
      max_q <= '0;
      sec_q <= '0;
      idx_q <= '0;
    end else begin
      for (int unsigned j = 0; j < LANES; j++) begin
        agree_q[j] <= agree_d[j];
      end
      max_q <= max_d;
      sec_q <= sec_d;
      idx_q <= idx_d;
    end
  end

  assign max_o = max_q;
  assign sec_o = sec_q;
  assign idx_o = idx_q;

endmodule

// File: rtl/rx_ccsk_corr_engine.sv
// CCSK despreader: correlates one chip word against all stored sequences,
// LANES per cycle. Optional erasure flag under CCSK_ERASURE_EN.
module rx_ccsk_corr_engine
  import rx_ccsk_pkg::*;
#(
  parameter int unsigned CHIP_W   = 32,
  parameter int unsigned SYM_BITS = $clog2(CCSK_SEQ_NUM),
  parameter int unsigned LANES    = 4,
  parameter int unsigned PW       = calc_pw(CHIP_W)
) (
  input  logic                              logic_clk_in,
  input  logic                              logic_rst_n_in,
  input  logic                              data_valid_in,
  output logic                              data_ready_out,
  input  logic [CHIP_W-1:0]                 data_ccsk_in,
  output logic                              seq_rd_en_out,
  output logic [SYM_BITS-$clog2(LANES)-1:0] seq_rd_addr_out,
  input  logic [LANES*CHIP_W-1:0]           seq_data_in,
  input  logic [PW-1:0]                     thresh_in,
  output logic                              sym_valid_out,
  input  logic                              sym_ready_in,
  output logic [SYM_BITS-1:0]               sym_data_out,
  output logic [PW-1:0]                     sym_peak_out,
  output logic [PW-1:0]                     sym_margin_out,
  output logic                              sym_erasure_out,
  output logic                              busy_out
);

  localparam int unsigned ROW_W  = SYM_BITS - $clog2(LANES);
  localparam int unsigned ROWS   = 2 ** ROW_W;
  localparam int unsigned LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned TAG_W  = ROW_W + 2;
  localparam int unsigned TAG_V  = ROW_W + 1;
  localparam int unsigned TAG_L  = ROW_W;

  state_e              state_q, state_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [CHIP_W-1:0]   word_q, word_d;
  logic                init_q, init_d;
  logic [TAG_W-1:0]    s1_tag_q, s1_tag_d;
  logic [TAG_W-1:0]    s2_tag_q, s2_tag_d;
  logic [TAG_W-1:0]    s3_tag_q, s3_tag_d;
  logic                s4_last_q, s4_last_d;
  logic [PW-1:0]       best_q, best_d;
  logic [PW-1:0]       sec_q, sec_d;
  logic [SYM_BITS-1:0] bidx_q, bidx_d;
  logic [SYM_BITS-1:0] res_sym_q, res_sym_d;
  logic [PW-1:0]       res_peak_q, res_peak_d;
  logic [PW-1:0]       res_margin_q, res_margin_d;

  logic [PW-1:0]       lane_max, lane_sec;
  logic [LIDX_W-1:0]   lane_idx;
  logic [SYM_BITS-1:0] cand_sym;
  logic                load_res;
  logic                rd_last;

  rx_ccsk_lane_max #(
    .CHIP_W (CHIP_W),
    .LANES  (LANES),
    .PW     (PW),
    .LIDX_W (LIDX_W)
  ) u_lane_max (
    .clk    (logic_clk_in),
    .rst_n  (logic_rst_n_in),
    .word_i (word_q),
    .seq_i  (seq_data_in),
    .max_o  (lane_max),
    .sec_o  (lane_sec),
    .idx_o  (lane_idx)
  );

  assign data_ready_out  = init_q && (state_q == ST_IDLE);
  assign seq_rd_en_out   = (state_q == ST_FETCH);
  assign seq_rd_addr_out = row_q;
  assign rd_last         = seq_rd_en_out && (row_q == ROW_W'(ROWS - 1));
  assign cand_sym        = SYM_BITS'(32'(s3_tag_q[ROW_W-1:0]) * LANES + 32'(lane_idx));
  assign load_res        = (state_q == ST_DRAIN) && s4_last_q;

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    word_d       = word_q;
    init_d       = 1'b1;
    s1_tag_d     = {seq_rd_en_out, rd_last, row_q};
    s2_tag_d     = s1_tag_q;
    s3_tag_d     = s2_tag_q;
    s4_last_d    = s3_tag_q[TAG_V] && s3_tag_q[TAG_L];
    best_d       = best_q;
    sec_d        = sec_q;
    bidx_d       = bidx_q;
    res_sym_d    = res_sym_q;
    res_peak_d   = res_peak_q;
    res_margin_d = res_margin_q;

    // Strict greater keeps the earlier (lower) symbol on ties; the loser
    // of the compare is what competes for second place.
    if (s3_tag_q[TAG_V]) begin
      if (lane_max > best_q) begin
        best_d = lane_max;
        bidx_d = cand_sym;
        sec_d  = (best_q > lane_sec) ? best_q : lane_sec;
      end else if (lane_max > sec_q) begin
        sec_d = lane_max;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (data_valid_in && data_ready_out) begin
          word_d  = data_ccsk_in;
          best_d  = '0;
          sec_d   = '0;
          bidx_d  = '0;
          row_d   = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        row_d = row_q + 1'b1;
        if (rd_last) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (load_res) begin
          res_sym_d    = bidx_q;
          res_peak_d   = best_q;
          res_margin_d = best_q - sec_q;
          state_d      = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (sym_ready_in) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge logic_clk_in or negedge logic_rst_n_in) begin
    if (!logic_rst_n_in) begin
      state_q      <= ST_IDLE;
      row_q        <= '0;
      word_q       <= '0;
      init_q       <= 1'b0;
      s1_tag_q     <= '0;
      s2_tag_q     <= '0;
      s3_tag_q     <= '0;
      s4_last_q    <= 1'b0;
      best_q       <= '0;
      sec_q        <= '0;
      bidx_q       <= '0;
      res_sym_q    <= '0;
      res_peak_q   <= '0;
      res_margin_q <= '0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      word_q       <= word_d;
      init_q       <= init_d;
      s1_tag_q     <= s1_tag_d;
      s2_tag_q     <= s2_tag_d;
      s3_tag_q     <= s3_tag_d;
      s4_last_q    <= s4_last_d;
      best_q       <= best_d;
      sec_q        <= sec_d;
      bidx_q       <= bidx_d;
      res_sym_q    <= res_sym_d;
      res_peak_q   <= res_peak_d;
      res_margin_q <= res_margin_d;
    end
  end

`ifdef CCSK_ERASURE_EN
  logic eras_q, eras_d;

  always_comb begin
    eras_d = eras_q;
    if (load_res) begin
      eras_d = (best_q < thresh_in) || (best_q == sec_q);
    end
  end

  always_ff @(posedge logic_clk_in or negedge logic_rst_n_in) begin
    if (!logic_rst_n_in) begin
      eras_q <= 1'b0;
    end else begin
      eras_q <= eras_d;
    end
  end

  assign sym_erasure_out = eras_q;
`else
  logic unused_thresh;
  assign unused_thresh   = ^thresh_in;
  assign sym_erasure_out = 1'b0;
`endif

  assign sym_valid_out  = (state_q == ST_HOLD);
  assign busy_out       = (state_q != ST_IDLE);
  assign sym_data_out   = res_sym_q;
  assign sym_peak_out   = res_peak_q;
  assign sym_margin_out = res_margin_q;

endmodule
